// File: rtl/minisys_pipe_pkg.sv
// Minisys-1A pipeline shared constants.
// Bundle widths, field offsets and reset images per stage.
package minisys_pipe_pkg;

   localparam int unsigned IF_ID_W  = 64;
   localparam int unsigned ID_EX_W  = 224;
   localparam int unsigned EX_MEM_W = 286;
   localparam int unsigned MEM_WB_W = 106;

   localparam int unsigned IF_ID_PC_LSB    = 0;
   localparam int unsigned IF_ID_INSTR_LSB = 32;

   localparam int unsigned ID_EX_PC_LSB   = 0;
   localparam int unsigned ID_EX_RS_LSB   = 32;
   localparam int unsigned ID_EX_RT_LSB   = 64;
   localparam int unsigned ID_EX_IMM_LSB  = 96;
   localparam int unsigned ID_EX_CTRL_LSB = 128;

   localparam int unsigned EX_MEM_PC_LSB       = 0;
   localparam int unsigned EX_MEM_ALU_LSB      = 32;
   localparam int unsigned EX_MEM_CP0_LSB      = 64;
   localparam int unsigned EX_MEM_WDATA_LSB    = 96;
   localparam int unsigned EX_MEM_CTRL_LSB     = 128;
   localparam int unsigned EX_MEM_NONFLUSH_BIT = 285;

   localparam int unsigned MEM_WB_RES_LSB  = 0;
   localparam int unsigned MEM_WB_RD_LSB   = 32;
   localparam int unsigned MEM_WB_CTRL_LSB = 64;

   localparam logic [IF_ID_W-1:0]  IF_ID_RESET_VAL  = '0;
   localparam logic [ID_EX_W-1:0]  ID_EX_RESET_VAL  = '0;
   localparam logic [MEM_WB_W-1:0] MEM_WB_RESET_VAL = '0;

   // CP0 field idles at all-ones so an empty stage never matches a cause.
   localparam logic [EX_MEM_W-1:0] EX_MEM_RESET_VAL =
      {{(EX_MEM_W-96){1'b0}}, 32'hFFFF_FFFF, 64'h0};

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One stage-buffer entry: valid, bundle and nonflush bit.
// Load takes new contents, clear empties to RESET_VAL, else hold.
module pipe_stage_entry
   import minisys_pipe_pkg::*;
#(
   parameter int unsigned          DATA_W    = EX_MEM_W,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_nonflush,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              nonflush
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              nf_q, nf_d;

   // Next contents: load wins over clear, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      nf_d    = nf_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = d_data;
         nf_d    = d_nonflush;
      end else if (clear) begin
         valid_d = 1'b0;
         data_d  = RESET_VAL;
         nf_d    = 1'b0;
      end
   end

   // Entry state, captured on the falling clock edge.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VAL;
         nf_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         nf_q    <= nf_d;
      end
   end

   assign valid    = valid_q;
   assign data     = data_q;
   assign nonflush = nf_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Minisys-1A pipeline stage register with valid/ready handshake.
// Optional skid entry, flush with nonflush override, drop counter.
module pipe_stage_buf
   import minisys_pipe_pkg::*;
#(
   parameter int unsigned       DATA_W    = EX_MEM_W,
   parameter int unsigned       DEPTH     = 1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_nonflush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_nonflush,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [7:0]        drop_count
);

   logic              ent_v  [DEPTH];
   logic [DATA_W-1:0] ent_d  [DEPTH];
   logic              ent_nf [DEPTH];
   logic              ent_ld [DEPTH];
   logic              ent_cl [DEPTH];

   logic              slot_v   [4];
   logic [DATA_W-1:0] slot_d   [4];
   logic              slot_nf  [4];
   logic [1:0]        slot_src [4];

   logic       pop, acc, in_drop;
   logic [1:0] cnt;
   logic [1:0] kills;
   logic [8:0] drop_sum;

   logic [1:0] occ_q, occ_d;
   logic [7:0] drop_q, drop_d;

   // Build next FIFO image: drop popped head, squeeze out flushed
   // entries, append the incoming beat. slot_src 2 = incoming.
   // An upstream beat without nonflush dies during flush even when
   // the stage is full, since upstream is being flushed too.
   always_comb begin
      pop     = ent_v[0] & out_ready;
      acc     = in_valid & in_ready;
      in_drop = flush & in_valid & ~in_nonflush;
      kills   = {1'b0, in_drop};
      cnt     = 2'd0;
      for (int s = 0; s < 4; s++) begin
         slot_v[s]   = 1'b0;
         slot_d[s]   = RESET_VAL;
         slot_nf[s]  = 1'b0;
         slot_src[s] = 2'd3;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_v[i] && !(i == 0 && pop)) begin
            if (flush && !ent_nf[i]) begin
               kills = kills + 2'd1;
            end else begin
               slot_v[cnt]   = 1'b1;
               slot_d[cnt]   = ent_d[i];
               slot_nf[cnt]  = ent_nf[i];
               slot_src[cnt] = 2'(i);
               cnt           = cnt + 2'd1;
            end
         end
      end
      if (acc && (!flush || in_nonflush)) begin
         slot_v[cnt]   = 1'b1;
         slot_d[cnt]   = in_data;
         slot_nf[cnt]  = in_nonflush;
         slot_src[cnt] = 2'd2;
         cnt           = cnt + 2'd1;
      end
   end

   // Saturating drop counter and occupancy next values.
   always_comb begin
      drop_sum = {1'b0, drop_q} + {7'b0, kills};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      occ_d    = cnt;
   end

   // Occupancy and drop counter registers.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         occ_q  <= 2'd0;
         drop_q <= 8'd0;
      end else begin
         occ_q  <= occ_d;
         drop_q <= drop_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      // An entry fed from itself just holds.
      assign ent_ld[g] = slot_v[g] && (slot_src[g] != 2'(g));
      assign ent_cl[g] = !slot_v[g] && ent_v[g];

      pipe_stage_entry #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_ent (
         .clock      (clock),
         .reset      (reset),
         .load       (ent_ld[g]),
         .clear      (ent_cl[g]),
         .d_data     (slot_d[g]),
         .d_nonflush (slot_nf[g]),
         .valid      (ent_v[g]),
         .data       (ent_d[g]),
         .nonflush   (ent_nf[g])
      );
   end

   if (DEPTH == 1) begin : g_rdy1
      assign in_ready = !ent_v[0] | out_ready;
   end else begin : g_rdy2
      logic rdy_q, rdy_d;

      // Registered ready keeps out_ready off the upstream path.
      always_comb begin
         rdy_d = (cnt < 2'd2);
      end

      // Ready register, open after reset.
      always_ff @(negedge clock or negedge reset) begin
         if (!reset) begin
            rdy_q <= 1'b1;
         end else begin
            rdy_q <= rdy_d;
         end
      end

      assign in_ready = rdy_q;
   end

   assign out_valid    = ent_v[0];
   assign out_data     = ent_d[0];
   assign out_nonflush = ent_nf[0];
   assign occupancy    = occ_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=1 instances
// against a queue model plus hand-computed literals.
module tb_pipe_stage_buf;

   localparam int W = 286;
   localparam logic [W-1:0] RV_A = {{(W-96){1'b0}}, 32'hFFFF_FFFF, 64'h0};
   localparam logic [W-1:0] RV_B = '0;

   typedef logic [W:0] ent_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic a_iv = 0, a_nf = 0, a_ordy = 0, a_fl = 0;
   logic [W-1:0] a_id = '0;
   logic a_ir, a_ov, a_onf;
   logic [W-1:0] a_od;
   logic [1:0] a_occ;
   logic [7:0] a_drop;

   logic b_iv = 0, b_nf = 0, b_ordy = 0, b_fl = 0;
   logic [W-1:0] b_id = '0;
   logic b_ir, b_ov, b_onf;
   logic [W-1:0] b_od;
   logic [1:0] b_occ;
   logic [7:0] b_drop;

   int nvec = 0;
   int nmis = 0;

   always #5 clock = ~clock;

   pipe_stage_buf #(.DATA_W(W), .DEPTH(2), .RESET_VAL(RV_A)) u_a (
      .clock(clock), .reset(reset),
      .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
      .in_nonflush(a_nf), .out_valid(a_ov), .out_ready(a_ordy),
      .out_data(a_od), .out_nonflush(a_onf), .flush(a_fl),
      .occupancy(a_occ), .drop_count(a_drop)
   );

   pipe_stage_buf #(.DATA_W(W), .DEPTH(1), .RESET_VAL(RV_B)) u_b (
      .clock(clock), .reset(reset),
      .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .in_nonflush(b_nf), .out_valid(b_ov), .out_ready(b_ordy),
      .out_data(b_od), .out_nonflush(b_onf), .flush(b_fl),
      .occupancy(b_occ), .drop_count(b_drop)
   );

   ent_t qa[$];
   ent_t qb[$];
   int   mda = 0;
   int   mdb = 0;

   function automatic bit rdy_a();
      return qa.size() < 2;
   endfunction

   function automatic bit rdy_b();
      return (qb.size() == 0) || b_ordy;
   endfunction

   // Queue model: pop head, kill unprotected survivors, append beat.
   task automatic mstep(input int depth, inout ent_t q[$],
                        inout int drop, input bit rdy,
                        input logic iv, input logic [W-1:0] id,
                        input logic nf, input logic ordy,
                        input logic fl);
      ent_t keep[$];
      int   k = 0;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      foreach (q[i]) begin
         if (fl && !q[i][W]) k++;
         else keep.push_back(q[i]);
      end
      if (fl && iv && !nf) k++;
      if (iv && rdy && (!fl || nf)) keep.push_back({nf, id});
      if (keep.size() > depth) $fatal(1, "FAIL model overflow");
      q = keep;
      drop = (drop + k > 255) ? 255 : drop + k;
   endtask

   always @(negedge clock or negedge reset) begin
      if (!reset) begin
         qa.delete();
         qb.delete();
         mda = 0;
         mdb = 0;
      end else begin
         bit ra, rb;
         ra = rdy_a();
         rb = rdy_b();
         mstep(2, qa, mda, ra, a_iv, a_id, a_nf, a_ordy, a_fl);
         mstep(1, qb, mdb, rb, b_iv, b_id, b_nf, b_ordy, b_fl);
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Every active cycle: DUT outputs against the model.
   always @(posedge clock) begin
      if (reset) begin
         chk("a_valid", W'(a_ov), W'(qa.size() > 0));
         chk("a_data", a_od, qa.size() > 0 ? qa[0][W-1:0] : RV_A);
         chk("a_nf", W'(a_onf), W'(qa.size() > 0 ? qa[0][W] : 1'b0));
         chk("a_occ", W'(a_occ), W'(qa.size()));
         chk("a_drop", W'(a_drop), W'(mda));
         chk("a_rdy", W'(a_ir), W'(rdy_a()));
         chk("b_valid", W'(b_ov), W'(qb.size() > 0));
         chk("b_data", b_od, qb.size() > 0 ? qb[0][W-1:0] : RV_B);
         chk("b_nf", W'(b_onf), W'(qb.size() > 0 ? qb[0][W] : 1'b0));
         chk("b_occ", W'(b_occ), W'(qb.size()));
         chk("b_drop", W'(b_drop), W'(mdb));
         chk("b_rdy", W'(b_ir), W'(rdy_b()));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_a(input logic v, input logic [W-1:0] d,
                        input logic nf, input logic ordy,
                        input logic fl);
      a_iv = v; a_id = d; a_nf = nf; a_ordy = ordy; a_fl = fl;
   endtask

   task automatic set_b(input logic v, input logic [W-1:0] d,
                        input logic nf, input logic ordy,
                        input logic fl);
      b_iv = v; b_id = d; b_nf = nf; b_ordy = ordy; b_fl = fl;
   endtask

   initial begin
      #12 reset = 1'b1;
      tick();

      // Reset pulled low mid-cycle with a beat held.
      set_a(1, W'(32'h55), 0, 0, 0);
      tick();
      set_a(0, '0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("rst_valid", W'(a_ov), W'(0));
      chk("rst_data", a_od, RV_A);
      chk("rst_occ", W'(a_occ), W'(0));
      chk("rst_drop", W'(a_drop), W'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      chk("rel_rdy_a", W'(a_ir), W'(1));
      chk("rel_rdy_b", W'(b_ir), W'(1));
      tick();

      // Back-pressure fill of the skid buffer.
      set_a(1, W'(32'hA), 0, 0, 0);
      tick();
      set_a(1, W'(32'hB), 0, 0, 0);
      tick();
      set_a(0, '0, 0, 0, 0);
      chk("bp_occ", W'(a_occ), W'(2));
      chk("bp_rdy", W'(a_ir), W'(0));
      chk("bp_data", a_od, W'(32'hA));
      set_a(0, '0, 0, 1, 0);
      tick();
      chk("pop_data", a_od, W'(32'hB));
      chk("pop_occ", W'(a_occ), W'(1));
      chk("pop_rdy", W'(a_ir), W'(1));
      tick();

      // Flush keeps the nonflush entry, kills the rest.
      set_a(1, W'(32'hA), 0, 0, 0);
      tick();
      set_a(1, W'(32'hB), 1, 0, 0);
      tick();
      set_a(1, W'(32'hC), 0, 0, 1);
      tick();
      set_a(0, '0, 0, 0, 0);
      chk("fl_head", a_od, W'(32'hB));
      chk("fl_nf", W'(a_onf), W'(1));
      chk("fl_occ", W'(a_occ), W'(1));
      chk("fl_drop", W'(a_drop), W'(2));

      // Saturate the drop counter: two kills per pair.
      for (int i = 0; i < 150; i++) begin
         set_a(1, W'(i + 16), 0, 0, 0);
         tick();
         set_a(1, W'(i + 1000), 0, 0, 1);
         tick();
      end
      chk("sat_drop", W'(a_drop), W'(255));
      tick();
      set_a(0, '0, 0, 0, 0);
      chk("sat_hold", W'(a_drop), W'(255));
      chk("sat_head", a_od, W'(32'hB));
      set_a(0, '0, 0, 1, 0);
      tick();
      set_a(0, '0, 0, 0, 0);

      // DEPTH=1 pass-through, no bubbles.
      for (int i = 1; i <= 8; i++) begin
         set_b(1, W'(i), 0, 1, 0);
         tick();
         chk("pt_data", b_od, W'(i));
         chk("pt_rdy", W'(b_ir), W'(1));
      end
      set_b(0, '0, 0, 1, 0);
      tick();

      // DEPTH=1 flush while the head is popped.
      set_b(1, W'(32'hA), 0, 0, 0);
      tick();
      set_b(1, W'(32'hD), 1, 1, 1);
      tick();
      set_b(0, '0, 0, 0, 0);
      chk("fp_head", b_od, W'(32'hD));
      chk("fp_nf", W'(b_onf), W'(1));
      chk("fp_drop", W'(b_drop), W'(0));
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the Minisys-1A pipeline.
- Carries a DATA_W-bit packed bundle between two stages, for example IF/ID, ID/EX, EX/MEM or MEM/WB.
- Replaces fixed-width, always-load stage registers with a valid/ready handshake, stall, flush with a nonflush override, and an optional second (skid) entry so back-pressure does not create a combinational ready path.
- Captures on the falling edge of clock, as all pipeline stage registers do.

Parameters:
- DATA_W, 286: width of the packed stage bundle.
- DEPTH, 1: entries held. 1 is a plain stage register; 2 adds a skid entry. Only 1 and 2 are legal.
- RESET_VAL, all zeros: value that out_data shows when the stage is empty, after reset and after flush.

Ports:
- clock  in  1  stage clock; all state updates on its negedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream bundle.
- in_nonflush  in  1  beat is immune to flush (exception/CP0 path).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  DATA_W  head entry bundle.
- out_nonflush  out  1  nonflush bit of the head entry.
- flush  in  1  kill all entries whose nonflush bit is 0.
- occupancy  out  2  number of valid entries (0..DEPTH).
- drop_count  out  8  saturating count of beats killed by flush.

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries invalid; out_valid=0, out_data=RESET_VAL, out_nonflush=0.
  - occupancy=0, drop_count=0.
  - in_ready=1 once reset is released.
  - Reset asserted mid-transfer discards the beat; no partial state survives.
- Transfers:
  - Accept = in_valid & in_ready, sampled at negedge.
  - Pop = out_valid & out_ready, sampled at negedge.
  - Latency: an accepted beat appears on out_* immediately after that negedge (1 edge).
- DEPTH=1:
  - in_ready = !out_valid | out_ready (combinational through out_ready).
  - Simultaneous pop and accept replaces the entry in place.
- DEPTH=2:
  - in_ready = (occupancy<2), registered; there is no combinational path from out_ready.
  - Entries form a FIFO ordered head, tail:
    - Accept into an empty stage fills head.
    - Accept with 1 entry and no pop fills tail.
    - Accept with 1 entry and a pop replaces head.
    - Accept with 2 entries is impossible (in_ready=0).
    - Pop with 2 entries moves tail to head.
    - Pop and accept together with 2 entries cannot occur.
- Invalid entries hold RESET_VAL. out_data never shows stale data when out_valid=0.
- Flush (synchronous, highest priority):
  - At the negedge where flush=1, every stored entry with nonflush=0 is invalidated and set to RESET_VAL.
  - Entries with nonflush=1 survive and are compacted to head, keeping their order.
  - An incoming beat in the same cycle is accepted only if in_nonflush=1. Otherwise it is dropped and counted.
  - A pop in the same cycle still completes for the head.
  - drop_count += number of killed valid entries plus the dropped incoming beat, saturating at 255.
- occupancy always equals the number of valid entries after each edge.
- Out of scope: no data transformation; no interpretation of DATA_W fields.

Decomposition:
- Shared package minisys_pipe_pkg holds:
  - per-stage bundle widths (IF_ID_W, ID_EX_W, EX_MEM_W=286, MEM_WB_W);
  - field offset constants for each bundle, e.g. EX_MEM_NONFLUSH_BIT=285;
  - per-stage RESET_VAL constants (EX_MEM reset has bits 95:64 = 0xFFFF_FFFF).
- One natural sub-module: pipe_stage_entry, a single entry with valid, data, nonflush and load/clear/hold control, instantiated DEPTH times.
- The saturating counter is inline.

Test Plan:
- Reset and defaults: DEPTH=2, DATA_W=286, RESET_VAL with bits 95:64=0xFFFF_FFFF. Pull reset low mid-cycle → out_valid=0, out_data bits 95:64=0xFFFF_FFFF and the rest 0, occupancy=0, drop_count=0; after release, in_ready=1.
- Back-pressure fill: DEPTH=2, out_ready=0, push 0xA then 0xB → occupancy=2, in_ready=0, out_data=0xA. Raise out_ready for one edge → out_data=0xB, occupancy=1, in_ready=1.
- Pass-through: DEPTH=1, out_ready=1, stream 0x1..0x8 on consecutive cycles → each value appears 1 edge later, no bubbles, in_ready stays 1.
- Flush with nonflush: DEPTH=2 holding {0xA nonflush=0, 0xB nonflush=1}, flush=1 with incoming 0xC nonflush=0 → afterwards head=0xB, occupancy=1, drop_count=2.
- Flush during pop: DEPTH=1 holding 0xA, out_ready=1, flush=1, incoming 0xD nonflush=1 → 0xA consumed, head=0xD, drop_count unchanged.
- Counter saturation: repeated flushes killing 300 beats → drop_count=255 and holds.
